hazard5_instr_decompressor: RTL and testbench



---
 rtl/hazard5_instr_decompressor_pkg.sv | 50 +++++
 rtl/hazard5_instr_decompressor_if.sv | 10 +
 rtl/hazard5_instr_decompressor.sv | 134 +++++++++++++
 tb/tb_hazard5_instr_decompressor.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard5_instr_decompressor_pkg.sv
// RV32I opcode constants and instruction-format assembly helpers used when
// expanding RV32C encodings into full-width instructions.
package hazard5_instr_decompressor_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } rv_opcode_e;

  localparam logic [4:0] RegZero = 5'd0;
  localparam logic [4:0] RegRa   = 5'd1;
  localparam logic [4:0] RegSp   = 5'd2;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, rv_opcode_e op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, rv_opcode_e op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch and jump offsets are byte offsets; bit 0 is implicitly zero.
  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, rv_opcode_e op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, rv_opcode_e op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd, rv_opcode_e op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, rv_opcode_e op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

endpackage

// File: rtl/hazard5_instr_decompressor_if.sv
// Instruction bus between the decode stage (master) and the decompressor (slave).
interface hazard5_instr_decompressor_if;
  logic [31:0] instr_in;
  logic        instr_is_32bit;
  logic [31:0] instr_out;
  logic        invalid;

  modport master (output instr_in, input instr_is_32bit, input instr_out, input invalid);
  modport slave  (input instr_in, output instr_is_32bit, output instr_out, output invalid);
endinterface

// File: rtl/hazard5_instr_decompressor.sv
// Combinational RV32C expander: classifies the instruction width and rewrites
// 16-bit encodings into their RV32I equivalents, flagging reserved forms.
module hazard5_instr_decompressor
  import hazard5_instr_decompressor_pkg::*;
#(
  parameter bit PASSTHROUGH = 1'b0
) (
  input logic                          clk,
  input logic                          rst,
  hazard5_instr_decompressor_if.slave  bus
);

  // The block is stateless; clock and reset exist only for port uniformity.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  logic [15:0] c;
  logic [4:0]  rd, rs2, rs1p, rs2p;
  logic [11:0] imm_ci, imm_addi4spn, imm_lw, imm_addi16sp, imm_lwsp, imm_swsp;
  logic [19:0] imm_lui;
  logic [20:1] imm_j;
  logic [12:1] imm_b;
  logic [31:0] expanded;
  logic        illegal;

  always_comb begin
    c    = bus.instr_in[15:0];
    rd   = c[11:7];
    rs2  = c[6:2];
    rs1p = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};

    imm_ci       = {{6{c[12]}}, c[12], c[6:2]};
    imm_addi4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
    imm_lw       = {5'b0, c[5], c[12:10], c[6], 2'b00};
    imm_addi16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    imm_lwsp     = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    imm_swsp     = {4'b0, c[8:7], c[12:9], 2'b00};
    imm_lui      = {{15{c[12]}}, c[6:2]};
    imm_j        = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    imm_b        = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};

    expanded = 32'h0;
    illegal  = 1'b0;

    casez ({c[15:13], c[1:0]})
      5'b000_00: begin
        illegal  = (imm_addi4spn == 12'h0);
        expanded = enc_i(imm_addi4spn, RegSp, 3'b000, rs2p, OpImm);
      end
      5'b010_00: expanded = enc_i(imm_lw, rs1p, 3'b010, rs2p, OpLoad);
      5'b110_00: expanded = enc_s(imm_lw, rs2p, rs1p, 3'b010, OpStore);
      5'b000_01: expanded = enc_i(imm_ci, rd, 3'b000, rd, OpImm);
      5'b001_01: expanded = enc_j(imm_j, RegRa, OpJal);
      5'b010_01: expanded = enc_i(imm_ci, RegZero, 3'b000, rd, OpImm);
      5'b011_01: begin
        // rd == x2 selects C.ADDI16SP; every other rd is C.LUI.
        if (rd == RegSp) begin
          illegal  = (imm_addi16sp == 12'h0);
          expanded = enc_i(imm_addi16sp, RegSp, 3'b000, RegSp, OpImm);
        end else begin
          illegal  = ({c[12], c[6:2]} == 6'h0);
          expanded = enc_u(imm_lui, rd, OpLui);
        end
      end
      5'b100_01: begin
        unique case (c[11:10])
          2'b00: begin
            illegal  = c[12];
            expanded = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OpImm);
          end
          2'b01: begin
            illegal  = c[12];
            expanded = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OpImm);
          end
          2'b10: expanded = enc_i(imm_ci, rs1p, 3'b111, rs1p, OpImm);
          default: begin
            illegal = c[12];
            unique case (c[6:5])
              2'b00:   expanded = enc_r(7'b0100000, rs2p, rs1p, 3'b000, rs1p, OpReg);
              2'b01:   expanded = enc_r(7'b0000000, rs2p, rs1p, 3'b100, rs1p, OpReg);
              2'b10:   expanded = enc_r(7'b0000000, rs2p, rs1p, 3'b110, rs1p, OpReg);
              default: expanded = enc_r(7'b0000000, rs2p, rs1p, 3'b111, rs1p, OpReg);
            endcase
          end
        endcase
      end
      5'b101_01: expanded = enc_j(imm_j, RegZero, OpJal);
      5'b110_01: expanded = enc_b(imm_b, RegZero, rs1p, 3'b000, OpBranch);
      5'b111_01: expanded = enc_b(imm_b, RegZero, rs1p, 3'b001, OpBranch);
      5'b000_10: begin
        illegal  = c[12];
        expanded = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OpImm);
      end
      5'b010_10: begin
        illegal  = (rd == RegZero);
        expanded = enc_i(imm_lwsp, RegSp, 3'b010, rd, OpLoad);
      end
      5'b100_10: begin
        if (rs2 != RegZero) begin
          expanded = enc_r(7'b0000000, rs2, c[12] ? rd : RegZero, 3'b000, rd, OpReg);
        end else if (!c[12]) begin
          illegal  = (rd == RegZero);
          expanded = enc_i(12'h000, rd, 3'b000, RegZero, OpJalr);
        end else if (rd == RegZero) begin
          expanded = enc_i(12'h001, RegZero, 3'b000, RegZero, OpSystem);
        end else begin
          expanded = enc_i(12'h000, rd, 3'b000, RegRa, OpJalr);
        end
      end
      5'b110_10: expanded = enc_s(imm_swsp, rs2, RegSp, 3'b010, OpStore);
      // FP loads/stores, the reserved quadrant-0 slot and 32-bit encodings.
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    if (PASSTHROUGH) begin
      bus.instr_is_32bit = 1'b1;
      bus.instr_out      = bus.instr_in;
      bus.invalid        = 1'b0;
    end else begin
      bus.instr_is_32bit = (bus.instr_in[1:0] == 2'b11);
      if (bus.instr_is_32bit) begin
        bus.instr_out = bus.instr_in;
        bus.invalid   = 1'b0;
      end else begin
        bus.instr_out = illegal ? 32'h0 : expanded;
        bus.invalid   = illegal;
      end
    end
  end

endmodule

// File: tb/tb_hazard5_instr_decompressor.sv
// Self-checking bench: directed vectors, a full 16-bit sweep against an RVC
// reference model, random 32-bit words and the passthrough configuration.
module tb_hazard5_instr_decompressor;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard5_instr_decompressor_if bus0 ();
  hazard5_instr_decompressor_if bus1 ();

  hazard5_instr_decompressor #(.PASSTHROUGH(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  hazard5_instr_decompressor #(.PASSTHROUGH(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] DirIn [8] = '{32'h00500513, 32'h00004515, 32'hFFFF4515, 32'h00004502,
                                        32'h0000852E, 32'h00000001, 32'h00000000, 32'h00008002};
  localparam logic [31:0] DirOut [8] = '{32'h00500513, 32'h00500513, 32'h00500513, 32'h00012503,
                                         32'h00B00533, 32'h00000013, 32'h0, 32'h0};
  localparam logic DirIs32 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic DirInv  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // ---------------- reference model ----------------
  function automatic int fld(input int v, input int hi, input int lo);
    return (v >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] t_i(input int imm, input int rs1, input int f3, input int rd,
                                      input int op);
    return ((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  function automatic logic [31:0] t_s(input int imm, input int rs2, input int rs1, input int f3,
                                      input int op);
    return (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | (fld(imm, 4, 0) << 7) | op;
  endfunction

  function automatic logic [31:0] t_b(input int imm, input int rs2, input int rs1, input int f3,
                                      input int op);
    return (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
         | (f3 << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | op;
  endfunction

  function automatic logic [31:0] t_u(input int imm, input int rd, input int op);
    return (imm & 'hfffff000) | (rd << 7) | op;
  endfunction

  function automatic logic [31:0] t_j(input int imm, input int rd, input int op);
    return (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
         | (fld(imm, 19, 12) << 12) | (rd << 7) | op;
  endfunction

  function automatic logic [31:0] t_r(input int f7, input int rs2, input int rs1, input int f3,
                                      input int rd, input int op);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  // Returns {invalid, instr_out} for a 16-bit encoding.
  function automatic logic [32:0] ref_expand(input logic [15:0] h);
    int x, q, f3, rd, rs2, rdp, rs1p, simm6, imm, fs, f7;
    logic [31:0] w;
    bit bad;
    x = int'(h);
    q = fld(x, 1, 0);
    f3 = fld(x, 15, 13);
    rd = fld(x, 11, 7);
    rs2 = fld(x, 6, 2);
    rdp = 8 + fld(x, 4, 2);
    rs1p = 8 + fld(x, 9, 7);
    simm6 = fld(x, 6, 2) - (fld(x, 12, 12) * 32);
    w = 32'h0;
    bad = 1'b0;
    if (q == 0) begin
      case (f3)
        0: begin
          imm = (fld(x, 10, 7) << 6) | (fld(x, 12, 11) << 4) | (fld(x, 5, 5) << 3)
              | (fld(x, 6, 6) << 2);
          if (imm == 0) bad = 1'b1;
          else w = t_i(imm, 2, 0, rdp, 'h13);
        end
        2: w = t_i((fld(x, 12, 10) << 3) | (fld(x, 6, 6) << 2) | (fld(x, 5, 5) << 6),
                   rs1p, 2, rdp, 'h03);
        6: w = t_s((fld(x, 12, 10) << 3) | (fld(x, 6, 6) << 2) | (fld(x, 5, 5) << 6),
                   rdp, rs1p, 2, 'h23);
        default: bad = 1'b1;
      endcase
    end else if (q == 1) begin
      case (f3)
        0: w = t_i(simm6, rd, 0, rd, 'h13);
        1, 5: begin
          imm = (fld(x, 11, 11) << 4) | (fld(x, 10, 9) << 8) | (fld(x, 8, 8) << 10)
              | (fld(x, 7, 7) << 6) | (fld(x, 6, 6) << 7) | (fld(x, 5, 3) << 1)
              | (fld(x, 2, 2) << 5) - (fld(x, 12, 12) * 2048);
          w = t_j(imm, (f3 == 1) ? 1 : 0, 'h6f);
        end
        2: w = t_i(simm6, 0, 0, rd, 'h13);
        3: begin
          if (rd == 2) begin
            imm = (fld(x, 6, 6) << 4) | (fld(x, 5, 5) << 6) | (fld(x, 4, 3) << 7)
                | (fld(x, 2, 2) << 5) - (fld(x, 12, 12) * 512);
            if (imm == 0) bad = 1'b1;
            else w = t_i(imm, 2, 0, 2, 'h13);
          end else begin
            imm = simm6 * 4096;
            if (imm == 0) bad = 1'b1;
            else w = t_u(imm, rd, 'h37);
          end
        end
        4: begin
          case (fld(x, 11, 10))
            0, 1: begin
              if (fld(x, 12, 12) == 1) bad = 1'b1;
              else w = t_i(rs2 + ((fld(x, 11, 10) == 1) ? 'h400 : 0), rs1p, 5, rs1p, 'h13);
            end
            2: w = t_i(simm6, rs1p, 7, rs1p, 'h13);
            default: begin
              if (fld(x, 12, 12) == 1) bad = 1'b1;
              else begin
                case (fld(x, 6, 5))
                  0: begin fs = 0; f7 = 'h20; end
                  1: begin fs = 4; f7 = 0; end
                  2: begin fs = 6; f7 = 0; end
                  default: begin fs = 7; f7 = 0; end
                endcase
                w = t_r(f7, rdp, rs1p, fs, rs1p, 'h33);
              end
            end
          endcase
        end
        default: begin
          imm = (fld(x, 11, 10) << 3) | (fld(x, 6, 5) << 6) | (fld(x, 4, 3) << 1)
              | (fld(x, 2, 2) << 5) - (fld(x, 12, 12) * 256);
          w = t_b(imm, 0, rs1p, f3 - 6, 'h63);
        end
      endcase
    end else begin
      case (f3)
        0: begin
          if (fld(x, 12, 12) == 1) bad = 1'b1;
          else w = t_i(rs2, rd, 1, rd, 'h13);
        end
        2: begin
          if (rd == 0) bad = 1'b1;
          else w = t_i((fld(x, 12, 12) << 5) | (fld(x, 6, 4) << 2) | (fld(x, 3, 2) << 6),
                       2, 2, rd, 'h03);
        end
        4: begin
          if (fld(x, 12, 12) == 0) begin
            if (rs2 != 0) w = t_r(0, rs2, 0, 0, rd, 'h33);
            else if (rd == 0) bad = 1'b1;
            else w = t_i(0, rd, 0, 0, 'h67);
          end else begin
            if (rs2 != 0) w = t_r(0, rs2, rd, 0, rd, 'h33);
            else if (rd == 0) w = 32'h00100073;
            else w = t_i(0, rd, 0, 1, 'h67);
          end
        end
        6: w = t_s((fld(x, 12, 9) << 2) | (fld(x, 8, 7) << 6), rs2, 2, 2, 'h23);
        default: bad = 1'b1;
      endcase
    end
    return {bad, bad ? 32'h0 : w};
  endfunction

  // Returns {instr_is_32bit, invalid, instr_out} for a full word.
  function automatic logic [33:0] ref_full(input logic [31:0] w, input bit pass);
    logic [32:0] r;
    if (pass || w[1:0] == 2'b11) return {1'b1, 1'b0, w};
    r = ref_expand(w[15:0]);
    return {1'b0, r};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus0.instr_in = 32'h00004515;
    bus1.instr_in = 32'h00004515;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus0.instr_out !== 32'h00500513 || bus0.instr_is_32bit !== 1'b0 || bus0.invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut0: out=%08h is32=%b inv=%b, want 00500513/0/0",
               bus0.instr_out, bus0.instr_is_32bit, bus0.invalid);
    end
    n_tests++;
    if (bus1.instr_out !== 32'h00004515 || bus1.instr_is_32bit !== 1'b1 || bus1.invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut1: out=%08h is32=%b inv=%b, want 00004515/1/0",
               bus1.instr_out, bus1.instr_is_32bit, bus1.invalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus0.instr_in = DirIn[i];
      #1;
      n_tests++;
      if (bus0.instr_out !== DirOut[i] || bus0.instr_is_32bit !== DirIs32[i]
          || bus0.invalid !== DirInv[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] in=%08h: out=%08h is32=%b inv=%b, want %08h/%b/%b", i,
                 DirIn[i], bus0.instr_out, bus0.instr_is_32bit, bus0.invalid, DirOut[i],
                 DirIs32[i], DirInv[i]);
      end
    end
  endtask

  task automatic test_sign_ext();
    logic [15:0] h;
    logic [32:0] r;
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: h = 16'hB001 | (16'($urandom) & 16'h0FFC);          // C.J, offset negative
        1: h = 16'hD001 | (16'($urandom) & 16'h0FFC);          // C.BEQZ, offset negative
        default: h = 16'h7101 | (16'($urandom) & 16'h007C);    // C.ADDI16SP, imm negative
      endcase
      @(negedge clk);
      bus0.instr_in = {16'($urandom), h};
      #1;
      r = ref_expand(h);
      n_tests++;
      if (bus0.instr_out !== r[31:0] || bus0.instr_out[31] !== 1'b1 || bus0.invalid !== 1'b0) begin
        n_fail++;
        $display("FAIL sign_ext h=%04h: out=%08h inv=%b, want %08h/0 with bit31 set", h,
                 bus0.instr_out, bus0.invalid, r[31:0]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [32:0] r;
    for (int h = 0; h < 65536; h++) begin
      if ((h & 3) == 0) @(negedge clk);
      if ((h & 3) != 3) begin
        rst = 1'($urandom_range(0, 1));
        bus0.instr_in = {16'($urandom), 16'(h)};
        #1;
        r = ref_expand(16'(h));
        n_tests++;
        if (bus0.instr_out !== r[31:0] || bus0.invalid !== r[32]
            || bus0.instr_is_32bit !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep h=%04h: out=%08h inv=%b is32=%b, want %08h/%b/0", h,
                   bus0.instr_out, bus0.invalid, bus0.instr_is_32bit, r[31:0], r[32]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_32bit_and_passthrough();
    logic [31:0] w;
    logic [33:0] e0;
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if (i < 100) w[1:0] = 2'b11;
      @(negedge clk);
      rst = 1'($urandom_range(0, 1));
      bus0.instr_in = w;
      bus1.instr_in = w;
      #1;
      e0 = ref_full(w, 1'b0);
      n_tests++;
      if ({bus0.instr_is_32bit, bus0.invalid, bus0.instr_out} !== e0) begin
        n_fail++;
        $display("FAIL word_dut0 in=%08h: got %b/%b/%08h, want %b/%b/%08h", w,
                 bus0.instr_is_32bit, bus0.invalid, bus0.instr_out, e0[33], e0[32], e0[31:0]);
      end
      n_tests++;
      if (bus1.instr_out !== w || bus1.instr_is_32bit !== 1'b1 || bus1.invalid !== 1'b0) begin
        n_fail++;
        $display("FAIL passthrough in=%08h: got %b/%b/%08h, want 1/0/%08h", w,
                 bus1.instr_is_32bit, bus1.invalid, bus1.instr_out, w);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rst_toggle();
    logic [31:0] w;
    logic [33:0] e0;
    for (int i = 0; i < 6; i++) begin
      w = (i == 0) ? 32'h00004515 : $urandom;
      @(negedge clk);
      bus0.instr_in = w;
      bus1.instr_in = w;
      e0 = ref_full(w, 1'b0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rst = ~rst;
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus0.instr_is_32bit, bus0.invalid, bus0.instr_out} !== e0
            || bus1.instr_out !== w || bus1.instr_is_32bit !== 1'b1 || bus1.invalid !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_toggle in=%08h rst=%b: dut0 %b/%b/%08h want %b/%b/%08h, dut1 %08h",
                   w, rst, bus0.instr_is_32bit, bus0.invalid, bus0.instr_out, e0[33], e0[32],
                   e0[31:0], bus1.instr_out);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    bus0.instr_in = 32'h0;
    bus1.instr_in = 32'h0;
    test_reset();
    test_directed();
    test_sign_ext();
    test_exhaustive();
    test_32bit_and_passthrough();
    test_rst_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
